// File: rtl/regfile_rename_mp.sv
// Architectural register file with rename tracking (busy bit + ROB producer tag per register).
// Combinational operand read with commit bypass; commit, rename and flush update state on the clock edge.
module regfile_rename_mp #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int ROB_W   = 4,
    parameter int NREAD   = 2,
    parameter int NCOMMIT = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic [NREAD*$clog2(NREG)-1:0]   rd_addr,
    output logic [NREAD-1:0]            rd_ready,
    output logic [NREAD*XLEN-1:0]       rd_val,
    output logic [NREAD*ROB_W-1:0]      rd_tag,
    input  logic [NCOMMIT-1:0]          cm_valid,
    input  logic [NCOMMIT*ROB_W-1:0]    cm_tag,
    input  logic [NCOMMIT*$clog2(NREG)-1:0] cm_rd,
    input  logic [NCOMMIT*XLEN-1:0]     cm_val,
    input  logic                        up_valid,
    input  logic [$clog2(NREG)-1:0]     up_rd,
    input  logic [ROB_W-1:0]            up_tag,
    input  logic                        flush,
    output logic [$clog2(NREG):0]       busy_cnt
);

    localparam int AW = $clog2(NREG);
    localparam int CW = AW + 1;

    logic [XLEN-1:0]  val_q [NREG];
    logic [ROB_W-1:0] tag_q [NREG];
    logic [NREG-1:0]  busy_q;
    logic [CW-1:0]    busy_cnt_q;

    logic [XLEN-1:0]  val_d [NREG];
    logic [ROB_W-1:0] tag_d [NREG];
    logic [NREG-1:0]  busy_d;

    function automatic logic [CW-1:0] popcount(input logic [NREG-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int k = 0; k < NREG; k++) begin
            n = n + CW'(v[k]);
        end
        return n;
    endfunction

    // Later assignments win: commits in port order, then rename, then flush.
    always_comb begin
        val_d  = val_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        for (int j = 0; j < NCOMMIT; j++) begin
            if (cm_valid[j] && (cm_rd[j*AW +: AW] != '0)) begin
                val_d[cm_rd[j*AW +: AW]] = cm_val[j*XLEN +: XLEN];
                if (busy_q[cm_rd[j*AW +: AW]] &&
                    (tag_q[cm_rd[j*AW +: AW]] == cm_tag[j*ROB_W +: ROB_W])) begin
                    busy_d[cm_rd[j*AW +: AW]] = 1'b0;
                end
            end
        end
        if (up_valid && (up_rd != '0)) begin
            busy_d[up_rd] = 1'b1;
            tag_d[up_rd]  = up_tag;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NREG; k++) begin
                val_q[k] <= '0;
                tag_q[k] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else if (rdy) begin
            val_q      <= val_d;
            tag_q      <= tag_d;
            busy_q     <= busy_d;
            busy_cnt_q <= popcount(busy_d);
        end
    end

    assign busy_cnt = busy_cnt_q;

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]    a;
        logic             r_ready;
        logic [XLEN-1:0]  r_val;
        logic [ROB_W-1:0] r_tag;

        assign a = rd_addr[i*AW +: AW];

        // A commit carrying the register's live tag resolves the operand in the same cycle.
        always_comb begin
            r_ready = ~busy_q[a];
            r_val   = val_q[a];
            r_tag   = tag_q[a];
            if (busy_q[a]) begin
                for (int j = 0; j < NCOMMIT; j++) begin
                    if (cm_valid[j] && (cm_rd[j*AW +: AW] == a) &&
                        (cm_tag[j*ROB_W +: ROB_W] == tag_q[a])) begin
                        r_ready = 1'b1;
                        r_val   = cm_val[j*XLEN +: XLEN];
                    end
                end
            end
            if (a == '0) begin
                r_ready = 1'b1;
                r_val   = '0;
                r_tag   = '0;
            end
        end

        assign rd_ready[i]               = r_ready;
        assign rd_val[i*XLEN +: XLEN]    = r_val;
        assign rd_tag[i*ROB_W +: ROB_W]  = r_tag;
    end

endmodule

// File: tb/tb_regfile_rename_mp.sv
// Directed bench for regfile_rename_mp: rename, commit bypass, stale commits, flush, stall and reset.
module tb_regfile_rename_mp;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [9:0]  rd_addr;
    logic [1:0]  rd_ready;
    logic [63:0] rd_val;
    logic [7:0]  rd_tag;
    logic [1:0]  cm_valid;
    logic [7:0]  cm_tag;
    logic [9:0]  cm_rd;
    logic [63:0] cm_val;
    logic        up_valid;
    logic [4:0]  up_rd;
    logic [3:0]  up_tag;
    logic        flush;
    logic [5:0]  busy_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_rename_mp dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_val(rd_val), .rd_tag(rd_tag),
        .cm_valid(cm_valid), .cm_tag(cm_tag), .cm_rd(cm_rd), .cm_val(cm_val),
        .up_valid(up_valid), .up_rd(up_rd), .up_tag(up_tag),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cm_valid = 2'b00;
        up_valid = 1'b0;
        flush    = 1'b0;
        rdy      = 1'b1;
    endtask

    task automatic rename(input logic [4:0] r, input logic [3:0] t);
        up_valid = 1'b1; up_rd = r; up_tag = t;
        tick();
        up_valid = 1'b0;
    endtask

    task automatic commit0(input logic [4:0] r, input logic [3:0] t, input logic [31:0] v);
        cm_valid[0] = 1'b1; cm_rd[4:0] = r; cm_tag[3:0] = t; cm_val[31:0] = v;
    endtask

    task automatic commit1(input logic [4:0] r, input logic [3:0] t, input logic [31:0] v);
        cm_valid[1] = 1'b1; cm_rd[9:5] = r; cm_tag[7:4] = t; cm_val[63:32] = v;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; rd_addr = '0;
        cm_valid = '0; cm_tag = '0; cm_rd = '0; cm_val = '0;
        up_valid = 1'b0; up_rd = '0; up_tag = '0; flush = 1'b0;

        // reset state: x5 on port 0, x0 on port 1
        rd_addr = {5'd0, 5'd5};
        #12;
        check("rst_ready", rd_ready, 2'b11);
        check("rst_val", rd_val, 64'h0);
        check("rst_cnt", busy_cnt, 6'd0);
        rst = 1'b1;
        tick();

        // rename x5 -> tag 3, then bypass commit
        rename(5'd5, 4'd3);
        rd_addr = {5'd0, 5'd5};
        #1;
        check("ren_ready", rd_ready[0], 1'b0);
        check("ren_tag", rd_tag[3:0], 4'd3);
        check("ren_cnt", busy_cnt, 6'd1);
        commit0(5'd5, 4'd3, 32'hDEAD);
        #1;
        check("byp_ready", rd_ready[0], 1'b1);
        check("byp_val", rd_val[31:0], 32'hDEAD);
        tick(); idle();
        #1;
        check("cm_ready", rd_ready[0], 1'b1);
        check("cm_val", rd_val[31:0], 32'hDEAD);
        check("cm_cnt", busy_cnt, 6'd0);

        // stale commit on x7 (tag 2 after re-rename to tag 9)
        rename(5'd7, 4'd2);
        rename(5'd7, 4'd9);
        rd_addr = {5'd0, 5'd7};
        commit0(5'd7, 4'd2, 32'h11);
        #1;
        check("stale_nobyp", rd_ready[0], 1'b0);
        tick(); idle();
        #1;
        check("stale_busy", rd_ready[0], 1'b0);
        check("stale_tag", rd_tag[3:0], 4'd9);
        check("stale_val", rd_val[31:0], 32'h11);
        check("stale_cnt", busy_cnt, 6'd1);
        commit0(5'd7, 4'd9, 32'h22);
        #1;
        check("x7_byp", rd_val[31:0], 32'h22);
        tick(); idle();
        #1;
        check("x7_ready", rd_ready[0], 1'b1);
        check("x7_val", rd_val[31:0], 32'h22);

        // commit clearing x4 in the same cycle as a new rename of x4
        rename(5'd4, 4'd1);
        commit0(5'd4, 4'd1, 32'h44);
        up_valid = 1'b1; up_rd = 5'd4; up_tag = 4'd6;
        tick(); idle();
        rd_addr = {5'd0, 5'd4};
        #1;
        check("x4_busy", rd_ready[0], 1'b0);
        check("x4_tag", rd_tag[3:0], 4'd6);
        check("x4_val", rd_val[31:0], 32'h44);
        check("x4_cnt", busy_cnt, 6'd1);
        commit0(5'd4, 4'd6, 32'h45);
        tick(); idle();
        #1;
        check("x4_done", busy_cnt, 6'd0);

        // two commit ports to x8, only port 1 tag matches
        rename(5'd8, 4'd2);
        rd_addr = {5'd8, 5'd8};
        commit0(5'd8, 4'd1, 32'hA);
        commit1(5'd8, 4'd2, 32'hB);
        #1;
        check("x8_byp_ready", rd_ready, 2'b11);
        check("x8_byp_val", rd_val, {32'hB, 32'hB});
        tick(); idle();
        #1;
        check("x8_val", rd_val[31:0], 32'hB);
        check("x8_cnt", busy_cnt, 6'd0);

        // both ports match: highest port wins for bypass and write
        rename(5'd8, 4'd5);
        commit0(5'd8, 4'd5, 32'hC);
        commit1(5'd8, 4'd5, 32'hD);
        #1;
        check("x8_hi_byp", rd_val[31:0], 32'hD);
        tick(); idle();
        #1;
        check("x8_hi_val", rd_val[31:0], 32'hD);
        check("x8_hi_ready", rd_ready[0], 1'b1);

        // flush with concurrent rename and commit
        rename(5'd1, 4'd1);
        rename(5'd2, 4'd2);
        rename(5'd3, 4'd3);
        check("fl_pre_cnt", busy_cnt, 6'd3);
        flush = 1'b1;
        up_valid = 1'b1; up_rd = 5'd9; up_tag = 4'd4;
        commit0(5'd1, 4'd7, 32'h5);
        tick(); idle();
        rd_addr = {5'd9, 5'd1};
        #1;
        check("fl_ready19", rd_ready, 2'b11);
        check("fl_val1", rd_val[31:0], 32'h5);
        check("fl_cnt", busy_cnt, 6'd0);
        rd_addr = {5'd3, 5'd2};
        #1;
        check("fl_ready23", rd_ready, 2'b11);

        // stalled cycle: nothing changes
        rdy = 1'b0;
        commit0(5'd2, 4'd0, 32'h77);
        up_valid = 1'b1; up_rd = 5'd3; up_tag = 4'd8;
        tick(); idle();
        #1;
        check("stall_val2", rd_val[31:0], 32'h0);
        check("stall_ready", rd_ready, 2'b11);
        check("stall_cnt", busy_cnt, 6'd0);

        // x0 is never written nor busy
        commit0(5'd0, 4'd0, 32'h99);
        up_valid = 1'b1; up_rd = 5'd0; up_tag = 4'd1;
        tick(); idle();
        rd_addr = {5'd0, 5'd0};
        #1;
        check("x0_ready", rd_ready, 2'b11);
        check("x0_val", rd_val, 64'h0);
        check("x0_tag", rd_tag, 8'h0);
        check("x0_cnt", busy_cnt, 6'd0);

        // asynchronous reset mid-cycle
        rename(5'd5, 4'd3);
        rd_addr = {5'd7, 5'd5};
        #1;
        check("ar_pre_cnt", busy_cnt, 6'd1);
        check("ar_pre_val", rd_val, {32'h22, 32'hDEAD});
        #1;
        rst = 1'b0;
        #1;
        check("ar_cnt", busy_cnt, 6'd0);
        check("ar_ready", rd_ready, 2'b11);
        check("ar_val", rd_val, 64'h0);
        #3;
        rst = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
